// File: rtl/decode_stage_pkg.sv
// ============================================================================
// decode_stage_pkg : shared types and constants for the decode stage
// Rev 1.0
// ============================================================================
`default_nettype none

package decode_stage_pkg;

  localparam int REG_W = 4;
  localparam int IMM_W = 24;

  typedef enum logic [1:0] {
    TYPE_DP  = 2'b00,
    TYPE_LS  = 2'b01,
    TYPE_BR  = 2'b10,
    TYPE_ILL = 2'b11
  } instr_type_e;

  typedef enum logic [1:0] {
    IMM_ZE8  = 2'b00,
    IMM_ZE12 = 2'b01,
    IMM_SE24 = 2'b10
  } imm_ext_e;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'b00,
    BUF_ONE   = 2'b01,
    BUF_FULL  = 2'b10
  } buf_state_e;

  localparam logic [1:0] REGSRC_DP  = 2'b00;
  localparam logic [1:0] REGSRC_BR  = 2'b01;
  localparam logic [1:0] REGSRC_STR = 2'b10;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_CMP = 4'b1010;

  typedef struct packed {
    logic [3:0]       aluOperation;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rn;
    logic [REG_W-1:0] rm;
    logic [IMM_W-1:0] immediate;
    logic [3:0]       conditionFlags;
    logic [4:0]       loadStoreSignals;
    logic [1:0]       regSrc;
    imm_ext_e         cntrlImmExt;
    logic             cntrlCondFlags;
    logic             cntrlBranch;
    logic             cntrlPcSrc;
    logic             cntrlAluSrc;
    logic             cntrlRegWrite;
    logic             cntrlMemWrite;
    logic             cntrlMemtoReg;
    logic             illegal;
  } decoded_t;

  function automatic logic [IMM_W-1:0] extend_imm(input imm_ext_e ext, input logic [23:0] imm24);
    case (ext)
      IMM_ZE12: extend_imm = IMM_W'(imm24[11:0]);
      IMM_SE24: extend_imm = IMM_W'($signed(imm24));
      default:  extend_imm = IMM_W'(imm24[7:0]);
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/decode_stage_if.sv
// ============================================================================
// decode_stage_if : fetch-side and register-read-side handshake of the stage
// Rev 1.0
// ============================================================================
`default_nettype none

interface decode_stage_if #(
  parameter int INSTR_W = 32,
  parameter int CNT_W   = 8
);
  import decode_stage_pkg::*;

  logic               flush;
  logic               inValid;
  logic               inReady;
  logic [INSTR_W-1:0] instruction;
  logic               outValid;
  logic               outReady;
  decoded_t           decoded;
  logic [CNT_W-1:0]   illegalCount;

  modport master (
    output flush, inValid, instruction, outReady,
    input  inReady, outValid, decoded, illegalCount
  );

  modport slave (
    input  flush, inValid, instruction, outReady,
    output inReady, outValid, decoded, illegalCount
  );

endinterface

`default_nettype wire

// File: rtl/decode_logic.sv
// ============================================================================
// decode_logic : combinational instruction -> decoded bundle
// Rev 1.0
// ============================================================================
`default_nettype none

module decode_logic
  import decode_stage_pkg::*;
#(
  parameter int INSTR_W = 32
) (
  input  logic [INSTR_W-1:0] instruction,
  output decoded_t           decoded
);

  logic [31:0] ins;
  instr_type_e ity;
  imm_ext_e    ext;
  decoded_t    d;

  always_comb begin
    ins = instruction[31:0];
    ity = instr_type_e'(ins[27:26]);
    ext = IMM_ZE8;
    d   = '0;

    // register and condition fields are decoded for every type, including illegal
    d.conditionFlags = ins[31:28];
    d.rn             = ins[19:16];
    d.rd             = ins[15:12];
    d.rm             = ins[3:0];

    case (ity)
      TYPE_DP: begin
        d.aluOperation   = ins[24:21];
        d.cntrlAluSrc    = ins[25];
        d.cntrlCondFlags = ins[20];
        d.cntrlRegWrite  = (ins[24:21] != ALU_CMP);
        d.regSrc         = REGSRC_DP;
      end
      TYPE_LS: begin
        ext                = IMM_ZE12;
        d.cntrlAluSrc      = ins[25];
        d.aluOperation     = ins[23] ? ALU_ADD : ALU_SUB;
        d.loadStoreSignals = ins[24:20];
        if (ins[20]) begin
          d.cntrlRegWrite = 1'b1;
          d.cntrlMemtoReg = 1'b1;
        end else begin
          d.cntrlMemWrite = 1'b1;
          d.regSrc        = REGSRC_STR;
        end
      end
      TYPE_BR: begin
        ext           = IMM_SE24;
        d.cntrlBranch = 1'b1;
        d.cntrlPcSrc  = 1'b1;
        d.cntrlAluSrc = 1'b1;
        d.regSrc      = REGSRC_BR;
        d.aluOperation = ALU_ADD;
      end
      default: begin
        d.illegal = 1'b1;
      end
    endcase

    d.cntrlImmExt = ext;
    d.immediate   = extend_imm(ext, ins[23:0]);
    decoded       = d;
  end

endmodule

`default_nettype wire

// File: rtl/decode_stage.sv
// ============================================================================
// decode_stage : registered decoder with 2-entry skid buffer, flush and
//                saturating illegal-instruction counter
// Rev 1.0
// ============================================================================
`default_nettype none

module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int INSTR_W = 32,
  parameter int CNT_W   = 8
) (
  input  logic           clk,
  input  logic           rst,
  decode_stage_if.slave  bus
);

  decoded_t         in_decoded;
  buf_state_e       state_q, state_d;
  decoded_t         main_q, main_d;
  decoded_t         skid_q, skid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push;
  logic             pop;

  decode_logic #(
    .INSTR_W (INSTR_W)
  ) u_decode_logic (
    .instruction (bus.instruction),
    .decoded     (in_decoded)
  );

  assign bus.inReady      = (state_q != BUF_FULL);
  assign bus.outValid     = (state_q != BUF_EMPTY);
  assign bus.decoded      = main_q;
  assign bus.illegalCount = cnt_q;

  always_comb begin
    push    = bus.inValid && bus.inReady && !bus.flush;
    pop     = bus.outValid && bus.outReady;
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    cnt_d   = cnt_q;

    if (push && in_decoded.illegal && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    // main always holds the oldest entry, so it only changes when empty or popped
    if (bus.flush) begin
      state_d = BUF_EMPTY;
    end else begin
      case (state_q)
        BUF_EMPTY: begin
          if (push) begin
            main_d  = in_decoded;
            state_d = BUF_ONE;
          end
        end
        BUF_ONE: begin
          if (push && pop) begin
            main_d = in_decoded;
          end else if (push) begin
            skid_d  = in_decoded;
            state_d = BUF_FULL;
          end else if (pop) begin
            state_d = BUF_EMPTY;
          end
        end
        BUF_FULL: begin
          if (pop) begin
            main_d  = skid_q;
            state_d = BUF_ONE;
          end
        end
        default: begin
          state_d = BUF_EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= BUF_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

`default_nettype wire
